bsg_unscan_stream: RTL and testbench
====================================

Name: bsg_unscan_stream

Overview:
- Streaming inverse of the prefix scan: receives a width_p-bit scanned vector as width_p/chunk_p beats and emits the recovered original vector, one chunk per beat.
- XOR mode performs Gray-to-binary's inverse (binary-to-Gray style difference). OR and AND modes recover the canonical minimal source: first-set bit for OR, first-clear bit for AND.
- Sits on the receive side of links and arbiters that transmit scanned/thermometer masks serially. Carries the boundary bit across beats so results equal a full-width unscan.

Parameters:
- width_p, 8, total vector width; must be a multiple of chunk_p.
- chunk_p, 4, bits per beat; 1 <= chunk_p <= width_p.
- xor_p, 0, select XOR inverse.
- and_p, 0, select AND inverse.
- or_p, 1, select OR inverse. Exactly one of xor_p/and_p/or_p is 1; the simulation assertion fires otherwise.
- lo_to_hi_p, 0, 0: the scan ran hi-to-lo, beats arrive MSB chunk first. 1: the scan ran lo-to-hi, beats arrive LSB chunk first.

Ports:
- clk_i, in, 1, clock.
- reset_n_i, in, 1, asynchronous active-low reset.
- v_i, in, 1, input beat valid.
- data_i, in, chunk_p, scanned chunk.
- ready_o, out, 1, input beat accepted when v_i & ready_o.
- v_o, out, 1, output beat valid.
- data_o, out, chunk_p, recovered chunk.
- last_o, out, 1, data_o is the final beat of the vector.
- yumi_i, in, 1, consumer takes the output beat; legal only when v_o = 1.

Behaviour:
- Reset: interface is one clock; reset is asynchronous and active-low.
  - Reset values: v_o=0, data_o=0, last_o=0, beat counter=0, carry=fill.
  - Reset mid-vector discards the partial vector; the next accepted beat is beat 0.
- Fill value: 0 for XOR and OR; 1 for AND.
- Inverse function (hi-to-lo), with t = chunk and n = neighbour bit (t[k+1], or carry for the top bit):
  - XOR: o[k] = t[k] ^ n.
  - OR: o[k] = t[k] & ~n.
  - AND: o[k] = t[k] | ~n.
  - For lo_to_hi_p=1, the neighbour is t[k-1], and carry feeds bit 0.
- Carry register:
  - Set to fill at beat 0.
  - After each accepted beat, loads the chunk's trailing bit: bit 0 if hi-to-lo, bit chunk_p-1 if lo-to-hi.
- Beat counter:
  - Width $clog2(width_p/chunk_p), minimum 1.
  - Increments on accept and wraps to 0 after beat width_p/chunk_p-1.
  - When width_p == chunk_p, every beat is beat 0 and has last_o=1.
- Latency and handshake:
  - One registered stage: an accepted beat appears on data_o the next cycle.
  - ready_o = ~v_o | yumi_i, so one beat per cycle is sustained under full throughput.
  - Simultaneous accept and yumi: the output register is replaced; no bubble.
  - yumi without a new accept: v_o falls next cycle.
  - While v_o=1 & ~yumi_i: data_o and last_o hold stable, ready_o=0, and carry/counter are frozen.
- last_o is registered alongside data_o and is 1 for the beat that wraps the counter.
- No combinational path from v_i/data_i to v_o/data_o.

Decomposition:
- Shared package bsg_scan_pkg holds:
  - the op enum (e_scan_xor, e_scan_and, e_scan_or);
  - a function returning fill per op;
  - a function computing the chunk inverse given chunk, carry, op and direction.
- The forward scan streamer reuses the same package.
- One natural sub-module: bsg_unscan_chunk, a combinational chunk inverse with carry-in, instantiated once.
- The counter, carry register and output register live in the top level.

Test Plan:
- XOR, width 8, chunk 4, hi-to-lo: beats 1010 then 1010, yumi_i tied 1 -> data_o 1111 (last 0), then 1111 (last 1), each one cycle after accept.
- OR: beats 0011, 1111 -> data_o 0010 then 0000; carry after beat 0 is 1.
- AND: beats 1100, 0000 -> data_o 1101 then 1111.
- lo_to_hi_p=1, XOR: beats 0101 (LSB chunk), 0101 -> data_o 1111, 1111.
- Backpressure: hold yumi_i=0 for 3 cycles after the first output -> ready_o=0, data_o held, second beat not consumed; release yumi -> same values as the XOR case, and back-to-back vectors restart the carry at fill.
- Reset mid-vector: assert reset_n_i low after beat 0 -> v_o=0 immediately; next vector 1010,1010 -> 1111, 1111 with correct last_o.

Source files
------------

// File: rtl/bsg_scan_pkg.sv
// Shared scan/unscan definitions: op encoding, fill value and chunk inverse.
package bsg_scan_pkg;

   // Widest chunk the helper functions handle.
   localparam int scan_max_chunk_gp = 64;

   typedef enum logic [1:0] {
      e_scan_xor,
      e_scan_and,
      e_scan_or
   } e_scan_op;

   // Value shifted in at the vector edge: AND scans start from all-ones.
   function automatic logic scan_fill(e_scan_op op);
      return (op == e_scan_and);
   endfunction

   // Undo a scan over one chunk of width w.  carry is the neighbour of the
   // first bit the scan touched within this chunk (top bit for hi-to-lo,
   // bit 0 for lo-to-hi).
   function automatic logic [scan_max_chunk_gp-1:0] scan_chunk_inverse
     (logic [scan_max_chunk_gp-1:0] t, int w, logic carry, e_scan_op op,
      logic lo_to_hi);
      logic [scan_max_chunk_gp-1:0] mask, tm, n, o;
      mask = (w >= scan_max_chunk_gp) ? '1
           : ((scan_max_chunk_gp'(1) << w) - scan_max_chunk_gp'(1));
      tm = t & mask;
      if (lo_to_hi)
         n = (tm << 1) | scan_max_chunk_gp'(carry);
      else
         n = (tm >> 1) | (scan_max_chunk_gp'(carry) << (w - 1));
      case (op)
         e_scan_xor: o = tm ^ n;
         e_scan_or:  o = tm & ~n;
         default:    o = tm | ~n;
      endcase
      return o & mask;
   endfunction

endpackage

// File: rtl/bsg_unscan_stream_if.sv
// Beat-stream handshake between a scanned-chunk producer and the unscanner.
interface bsg_unscan_stream_if #(parameter int chunk_p = 4);
   logic               v_i;
   logic [chunk_p-1:0] data_i;
   logic               ready_o;
   logic               v_o;
   logic [chunk_p-1:0] data_o;
   logic               last_o;
   logic               yumi_i;

   modport slave  (input  v_i, data_i, yumi_i,
                   output ready_o, v_o, data_o, last_o);
   modport master (output v_i, data_i, yumi_i,
                   input  ready_o, v_o, data_o, last_o);
endinterface

// File: rtl/bsg_unscan_chunk.sv
// Combinational inverse of one scanned chunk, with the cross-beat carry in.
module bsg_unscan_chunk
   import bsg_scan_pkg::*;
#(
   parameter int       chunk_p    = 4,
   parameter e_scan_op op_p       = e_scan_or,
   parameter int       lo_to_hi_p = 0
) (
   input  logic [chunk_p-1:0] data_i,
   input  logic               carry_i,
   output logic [chunk_p-1:0] data_o
);

   assign data_o = chunk_p'(scan_chunk_inverse(scan_max_chunk_gp'(data_i),
                                               chunk_p, carry_i, op_p,
                                               (lo_to_hi_p != 0)));

endmodule

// File: rtl/bsg_unscan_stream.sv
// Streaming unscan: one scanned chunk in per beat, one recovered chunk out,
// with the boundary bit carried across beats of the same vector.
module bsg_unscan_stream
   import bsg_scan_pkg::*;
#(
   parameter int width_p    = 8,
   parameter int chunk_p    = 4,
   parameter int xor_p      = 0,
   parameter int and_p      = 0,
   parameter int or_p       = 1,
   parameter int lo_to_hi_p = 0
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   bsg_unscan_stream_if.slave  io
);

   localparam int       beats_lp = width_p / chunk_p;
   localparam int       cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam e_scan_op op_lp    = (xor_p != 0) ? e_scan_xor
                                 : (and_p != 0) ? e_scan_and : e_scan_or;
   localparam logic     fill_lp  = scan_fill(op_lp);

   logic [cnt_w_lp-1:0] cnt_r;
   logic                carry_r;
   logic                v_r, last_r;
   logic [chunk_p-1:0]  data_r;
   logic [chunk_p-1:0]  inv;
   logic                accept, last_beat, carry_in, trail_bit;

   assign io.ready_o = ~v_r | io.yumi_i;
   assign io.v_o     = v_r;
   assign io.data_o  = data_r;
   assign io.last_o  = last_r;

   assign accept    = io.v_i & io.ready_o;
   assign last_beat = (cnt_r == cnt_w_lp'(beats_lp - 1));
   // Beat 0 always starts from the fill value, whatever the last vector left.
   assign carry_in  = (cnt_r == '0) ? fill_lp : carry_r;
   assign trail_bit = (lo_to_hi_p != 0) ? io.data_i[chunk_p-1] : io.data_i[0];

   bsg_unscan_chunk #(
      .chunk_p    (chunk_p),
      .op_p       (op_lp),
      .lo_to_hi_p (lo_to_hi_p)
   ) chunk_inv (
      .data_i  (io.data_i),
      .carry_i (carry_in),
      .data_o  (inv)
   );

   // Beat counter and carry advance only on an accepted beat.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_r   <= '0;
         carry_r <= fill_lp;
      end else if (accept) begin
         cnt_r   <= last_beat ? '0 : cnt_r + 1'b1;
         carry_r <= trail_bit;
      end
   end

   // Output register: reload on accept, drain on yumi, otherwise hold.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_r    <= 1'b0;
         data_r <= '0;
         last_r <= 1'b0;
      end else if (accept) begin
         v_r    <= 1'b1;
         data_r <= inv;
         last_r <= last_beat;
      end else if (io.yumi_i) begin
         v_r    <= 1'b0;
      end
   end

   // Exactly one scan operator must be selected.
   always_ff @(posedge clk_i) begin
      assert (xor_p + and_p + or_p == 1);
   end

endmodule

// File: tb/tb_bsg_unscan_stream.sv
// Drives five unscan configurations with a shared beat stream and checks
// each against a full-vector bit-position model of the unscan.
module tb_bsg_unscan_stream;

   localparam int NCFG = 5;

   // cfg 0: XOR hi-to-lo, 1: OR, 2: AND, 3: XOR lo-to-hi, 4: OR width=chunk=4
   function automatic int cfg_w(int k);   return (k == 4) ? 4 : 8; endfunction
   function automatic int cfg_op(int k);  // 0 xor, 1 and, 2 or
      return (k == 0 || k == 3) ? 0 : (k == 2) ? 1 : 2;
   endfunction
   function automatic int cfg_l2h(int k); return (k == 3) ? 1 : 0; endfunction

   logic       clk = 1'b0;
   logic       reset_n_i = 1'b0;
   logic       v_i = 1'b0;
   logic [3:0] data_i = '0;
   logic       yumi_i = 1'b0;

   logic       rdy_a  [NCFG];
   logic       v_a    [NCFG];
   logic [3:0] dat_a  [NCFG];
   logic       last_a [NCFG];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NCFG; k++) begin : g_dut
      bsg_unscan_stream_if #(.chunk_p(4)) ifc ();
      assign ifc.v_i    = v_i;
      assign ifc.data_i = data_i;
      assign ifc.yumi_i = yumi_i;
      assign rdy_a[k]   = ifc.ready_o;
      assign v_a[k]     = ifc.v_o;
      assign dat_a[k]   = ifc.data_o;
      assign last_a[k]  = ifc.last_o;

      bsg_unscan_stream #(
         .width_p    (cfg_w(k)),
         .chunk_p    (4),
         .xor_p      (cfg_op(k) == 0 ? 1 : 0),
         .and_p      (cfg_op(k) == 1 ? 1 : 0),
         .or_p       (cfg_op(k) == 2 ? 1 : 0),
         .lo_to_hi_p (cfg_l2h(k))
      ) dut (
         .clk_i     (clk),
         .reset_n_i (reset_n_i),
         .io        (ifc)
      );
   end

   int nchk = 0;
   int npass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: scanned bits stored by absolute vector position.
   bit         mv;
   int         mb   [NCFG];
   bit         mvec [NCFG][8];
   logic [3:0] md   [NCFG];
   bit         ml   [NCFG];

   function automatic bit unscan_bit(int op, bit t, bit n);
      case (op)
         0:       return t ^ n;
         1:       return t | ~n;
         default: return t & ~n;
      endcase
   endfunction

   function automatic int abs_pos(int k, int b, int j);
      return cfg_l2h(k) ? b * 4 + j : cfg_w(k) - (b + 1) * 4 + j;
   endfunction

   task automatic model_reset();
      mv = 0;
      for (int k = 0; k < NCFG; k++) mb[k] = 0;
   endtask

   task automatic model_clock();
      if (v_i && (!mv || yumi_i)) begin
         for (int k = 0; k < NCFG; k++) begin
            int w = cfg_w(k);
            int b = mb[k];
            bit fill = (cfg_op(k) == 1);
            for (int j = 0; j < 4; j++) mvec[k][abs_pos(k, b, j)] = data_i[j];
            for (int j = 0; j < 4; j++) begin
               int a  = abs_pos(k, b, j);
               int nb = cfg_l2h(k) ? a - 1 : a + 1;
               bit n  = (nb < 0 || nb >= w) ? fill : mvec[k][nb];
               md[k][j] = unscan_bit(cfg_op(k), mvec[k][a], n);
            end
            ml[k] = (b == w / 4 - 1);
            mb[k] = ml[k] ? 0 : b + 1;
         end
         mv = 1;
      end else if (yumi_i) begin
         mv = 0;
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NCFG; k++) begin
         chk($sformatf("c%0d_ready", k), 32'(rdy_a[k]), 32'(!mv || yumi_i));
         chk($sformatf("c%0d_v", k), 32'(v_a[k]), 32'(mv));
         if (mv) begin
            chk($sformatf("c%0d_data", k), 32'(dat_a[k]), 32'(md[k]));
            chk($sformatf("c%0d_last", k), 32'(last_a[k]), 32'(ml[k]));
         end
      end
   endtask

   // One cycle: drive at the negedge, clock, then compare at the next negedge.
   task automatic tick(input bit v, input logic [3:0] d, input bit y);
      v_i    = v;
      data_i = d;
      yumi_i = y & mv;
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      model_reset();
      #12;
      for (int k = 0; k < NCFG; k++) begin
         chk($sformatf("rst_c%0d_v", k), 32'(v_a[k]), 32'd0);
         chk($sformatf("rst_c%0d_data", k), 32'(dat_a[k]), 32'd0);
         chk($sformatf("rst_c%0d_last", k), 32'(last_a[k]), 32'd0);
      end
      @(negedge clk);
      reset_n_i = 1'b1;

      // XOR hi-to-lo
      tick(1, 4'b1010, 1);
      chk("xor_b0_data", 32'(dat_a[0]), 32'hF);
      chk("xor_b0_last", 32'(last_a[0]), 32'd0);
      chk("w4_last", 32'(last_a[4]), 32'd1);
      tick(1, 4'b1010, 1);
      chk("xor_b1_data", 32'(dat_a[0]), 32'hF);
      chk("xor_b1_last", 32'(last_a[0]), 32'd1);
      // OR
      tick(1, 4'b0011, 1);
      chk("or_b0_data", 32'(dat_a[1]), 32'h2);
      tick(1, 4'b1111, 1);
      chk("or_b1_data", 32'(dat_a[1]), 32'h0);
      // AND
      tick(1, 4'b1100, 1);
      chk("and_b0_data", 32'(dat_a[2]), 32'hD);
      tick(1, 4'b0000, 1);
      chk("and_b1_data", 32'(dat_a[2]), 32'hF);
      // XOR lo-to-hi
      tick(1, 4'b0101, 1);
      chk("l2h_b0_data", 32'(dat_a[3]), 32'hF);
      tick(1, 4'b0101, 1);
      chk("l2h_b1_data", 32'(dat_a[3]), 32'hF);

      // Backpressure: output held, offered beat not taken
      tick(1, 4'b1010, 1);
      for (int i = 0; i < 3; i++) begin
         tick(1, 4'b0000, 0);
         chk("bp_ready", 32'(rdy_a[0]), 32'd0);
         chk("bp_hold", 32'(dat_a[0]), 32'hF);
      end
      tick(1, 4'b1010, 1);
      chk("bp_rel_data", 32'(dat_a[0]), 32'hF);
      chk("bp_rel_last", 32'(last_a[0]), 32'd1);
      tick(1, 4'b1010, 1);
      chk("b2b_b0_data", 32'(dat_a[0]), 32'hF);
      tick(1, 4'b1010, 1);
      chk("b2b_b1_last", 32'(last_a[0]), 32'd1);
      tick(0, 4'b0000, 1);

      // Randomised traffic
      for (int i = 0; i < 400; i++)
         tick($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 2) != 0);

      // Reset in the middle of a vector
      tick(0, 4'b0000, 1);
      tick(1, 4'b1010, 1);
      #2 reset_n_i = 1'b0;
      #1;
      model_reset();
      chk("midrst_v", 32'(v_a[0]), 32'd0);
      @(negedge clk);
      reset_n_i = 1'b1;
      v_i = 1'b0;
      yumi_i = 1'b0;
      tick(1, 4'b1010, 1);
      chk("midrst_b0_data", 32'(dat_a[0]), 32'hF);
      chk("midrst_b0_last", 32'(last_a[0]), 32'd0);
      tick(1, 4'b1010, 1);
      chk("midrst_b1_data", 32'(dat_a[0]), 32'hF);
      chk("midrst_b1_last", 32'(last_a[0]), 32'd1);
      tick(0, 4'b0000, 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
